skid_fifo: RTL and testbench
============================

Name: skid_fifo

Overview:
Parametrised successor to the two-entry pipeline skid buffer. It is an N-entry elastic buffer on a valid/ready stream in which data_out, valid_out and ready_in all come directly from registers, so no combinational path crosses the stage in either direction. It also reports occupancy and has an optional overwrite-oldest (circular) mode that raises a drop indication. It sits between pipeline stages wherever more than one cycle of back-pressure slack is needed.

Parameters:
DATA_WIDTH, 8, width of the data payload.
DEPTH, 4, total entries including the output register; legal range is 2 or more, and DEPTH=2 matches the existing two-entry skid buffer behaviour.
OVERWRITE_MODE, 0, 1 means the block always accepts input and drops the oldest entry when full.
ALMOST_FULL_LEVEL, DEPTH-1, occupancy at or above which almost_full asserts.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
data_in  in  DATA_WIDTH  input payload.
valid_in  in  1  input valid.
ready_in  out  1  input ready, registered.
data_out  out  DATA_WIDTH  output payload, registered (head of queue).
valid_out  out  1  output valid, registered.
ready_out  in  1  downstream ready.
count  out  $clog2(DEPTH+1)  registered occupancy, 0..DEPTH.
almost_full  out  1  registered; equals (count >= ALMOST_FULL_LEVEL).
dropped  out  1  registered one-cycle pulse; an entry was discarded in overwrite mode.

Behaviour:
- Reset (async assert) drives count=0, valid_out=0, ready_in=1, data_out=0, almost_full=0, dropped=0, and both pointers to 0. Any in-flight contents are discarded. There is no output glitch beyond the async transition.
- Handshakes:
  - insert = valid_in & ready_in.
  - remove = valid_out & ready_out.
  - valid_in while ready_in=0 is ignored, and the upstream must hold its data.
  - Once valid_out is asserted, data_out is stable until remove.
- Storage: the output register holds the head entry. A (DEPTH-1)-entry circular store holds the entries behind it, addressed by wr_ptr/rd_ptr of width $clog2(DEPTH-1), minimum 1 bit. Both pointers wrap from DEPTH-2 to 0.
- Occupancy states, defined in the package:
  - EMPTY: count=0.
  - BUSY: output register valid, store empty.
  - PARTIAL: store non-empty but not full.
  - FULL: count=DEPTH.
- Data routing per cycle:
  - Insert with store empty and (output empty or remove): data_in is written straight to the output register. Latency from EMPTY is 1 cycle (valid_out high on the cycle after insert).
  - Insert otherwise: data_in is written to store[wr_ptr], and wr_ptr increments.
  - Remove with store non-empty: store[rd_ptr] is written to the output register, and rd_ptr increments.
  - Remove with store empty and no insert: valid_out drops next cycle.
  - Simultaneous insert and remove: count is unchanged and FIFO order is preserved.
- Count update: count_next = count + insert - remove, except in the overwrite-drop case below.
- ready_in_next = (count_next < DEPTH) || OVERWRITE_MODE. It is registered, so a full buffer deasserts ready_in on the same edge that count reaches DEPTH, and no data is lost.
- valid_out_next = (count_next != 0).
- Overwrite drop (OVERWRITE_MODE=1, FULL, insert, no remove):
  - The output register loads store[rd_ptr], discarding the old head.
  - data_in is written to store[wr_ptr], and both pointers advance.
  - count stays at DEPTH, and dropped pulses high the next cycle.
- Overwrite mode, FULL, insert and remove together: normal flow with no drop.
- Non-overwrite mode: FULL with insert is impossible because ready_in=0.
- dropped is 0 in every other case, and it is always 0 when OVERWRITE_MODE=0.
- Illegal parameters (DEPTH<2 or ALMOST_FULL_LEVEL>DEPTH) are rejected by an elaboration-time check.

Decomposition:
- Package skid_fifo_pkg holds:
  - the occupancy enum (EMPTY, BUSY, PARTIAL, FULL) with 2-bit encoding;
  - the function count_width(depth) = $clog2(depth+1);
  - the function ptr_width(depth) = max(1, $clog2(depth-1)).
- One sub-module, skid_fifo_store: the (DEPTH-1)-entry register array with wr_ptr/rd_ptr, push/pop inputs and a head data output, all reset asynchronously.
- The top level holds the output register, the control and count logic, and the registered flags, all built with the team's register_slice.

Test Plan:
1. DEPTH=4: after reset with no stimulus → ready_in=1, valid_out=0, count=0, dropped=0. Assert rst mid-stream with count=3 → all outputs return to their reset values immediately.
2. DEPTH=4, ready_out=0: insert 0x11, 0x22, 0x33, 0x44 on consecutive cycles → count goes 1, 2, 3, 4. ready_in=0 on the cycle after the 4th insert. almost_full goes high once count=3. data_out=0x11 throughout.
3. From (2), hold ready_out=1 → outputs 0x11, 0x22, 0x33, 0x44 in order, one per cycle. ready_in=1 again the cycle after the first remove. valid_out=0 after 0x44 leaves.
4. DEPTH=4, valid_in=1 and ready_out=1 continuously with a counter payload → one word per cycle, count steady at 1, first output 1 cycle after the first insert, no gaps.
5. OVERWRITE_MODE=1, DEPTH=4, ready_out=0: insert 0x01..0x06 → after 0x05, data_out=0x02 and dropped pulses. After 0x06, data_out=0x03 and dropped pulses. count=4 throughout. Draining then yields 0x03, 0x04, 0x05, 0x06.
6. DEPTH=2 with random valid_in/ready_out over 10k cycles → output sequence equals input sequence (scoreboard). No transaction occurs while ready_in=0, and count matches the model every cycle.

Source files
------------

// File: rtl/skid_fifo_pkg.sv
// Shared types and sizing helpers for the skid_fifo elastic buffer.
// Occupancy classes and counter/pointer widths derived from DEPTH.
package skid_fifo_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        BUSY    = 2'd1,
        PARTIAL = 2'd2,
        FULL    = 2'd3
    } occ_e;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth - 1 > 1) ? $clog2(depth - 1) : 1;
    endfunction

endpackage

// File: rtl/skid_fifo_store.sv
// Circular store holding the entries queued behind the output register.
// Pointers wrap from DEPTH-2 back to 0.
module skid_fifo_store
    import skid_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] head_data
);

    localparam int ENTRIES = DEPTH - 1;
    localparam int PW      = ptr_width(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 2);

    logic [DATA_WIDTH-1:0] mem [ENTRIES];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= bump(wr_ptr);
            end
            if (pop) rd_ptr <= bump(rd_ptr);
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/skid_fifo.sv
// N-entry elastic buffer with fully registered outputs in both directions.
// Optional overwrite mode discards the oldest entry when full.
module skid_fifo
    import skid_fifo_pkg::*;
#(
    parameter int DATA_WIDTH        = 8,
    parameter int DEPTH             = 4,
    parameter int OVERWRITE_MODE    = 0,
    parameter int ALMOST_FULL_LEVEL = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic                         valid_in,
    output logic                         ready_in,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         valid_out,
    input  logic                         ready_out,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                         almost_full,
    output logic                         dropped
);

    localparam int CW = count_width(DEPTH);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C  = CW'(1);
    localparam logic [CW-1:0] AF_C   = CW'(ALMOST_FULL_LEVEL);
    localparam bit OVR = (OVERWRITE_MODE != 0);

    if (DEPTH < 2 || ALMOST_FULL_LEVEL > DEPTH) begin : g_bad_params
        $error("skid_fifo: illegal DEPTH or ALMOST_FULL_LEVEL");
    end

    occ_e                  occ;
    logic                  insert;
    logic                  remove;
    logic                  drop;
    logic                  store_empty;
    logic                  load_direct;
    logic                  push;
    logic                  pop;
    logic [CW-1:0]         count_next;
    logic [DATA_WIDTH-1:0] head_data;

    always_comb begin
        occ = EMPTY;
        unique case (1'b1)
            (count == '0):     occ = EMPTY;
            (count == FULL_C): occ = FULL;
            (count == ONE_C):  occ = BUSY;
            default:           occ = PARTIAL;
        endcase
    end

    assign insert      = valid_in & ready_in;
    assign remove      = valid_out & ready_out;
    assign drop        = OVR && (occ == FULL) && insert && !remove;
    assign store_empty = (occ == EMPTY) || (occ == BUSY);
    // Bypass the store only when the head slot is free this cycle.
    assign load_direct = insert && store_empty && ((occ == EMPTY) || remove);
    assign push        = insert && !load_direct;
    assign pop         = (remove || drop) && !store_empty;

    always_comb begin
        count_next = count;
        if (!drop) count_next = count + CW'(insert) - CW'(remove);
    end

    skid_fifo_store #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_store (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .wr_data  (data_in),
        .head_data(head_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            valid_out   <= 1'b0;
            ready_in    <= 1'b1;
            data_out    <= '0;
            almost_full <= 1'b0;
            dropped     <= 1'b0;
        end else begin
            count       <= count_next;
            valid_out   <= (count_next != '0);
            ready_in    <= (count_next < FULL_C) || OVR;
            almost_full <= (count_next >= AF_C);
            dropped     <= drop;
            if (pop)              data_out <= head_data;
            else if (load_direct) data_out <= data_in;
        end
    end

endmodule

// File: tb/tb_skid_fifo.sv
// Self-checking bench: vector tables, streaming, overwrite and a
// randomized DEPTH=2 run against a queue model.
module tb_skid_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int pass  = 0;

    logic       vin4 = 0, rout4 = 0, rdy4, vout4, af4, drp4;
    logic [7:0] din4 = 0, dout4;
    logic [2:0] cnt4;

    logic       vino = 0, routo = 0, rdyo, vouto, afo, drpo;
    logic [7:0] dino = 0, douto;
    logic [2:0] cnto;

    logic       vin2 = 0, rout2 = 0, rdy2, vout2, af2, drp2;
    logic [7:0] din2 = 0, dout2;
    logic [1:0] cnt2;

    skid_fifo #(.DATA_WIDTH(8), .DEPTH(4), .OVERWRITE_MODE(0)) u4 (
        .clk(clk), .rst(rst), .data_in(din4), .valid_in(vin4),
        .ready_in(rdy4), .data_out(dout4), .valid_out(vout4),
        .ready_out(rout4), .count(cnt4), .almost_full(af4),
        .dropped(drp4)
    );

    skid_fifo #(.DATA_WIDTH(8), .DEPTH(4), .OVERWRITE_MODE(1)) uo (
        .clk(clk), .rst(rst), .data_in(dino), .valid_in(vino),
        .ready_in(rdyo), .data_out(douto), .valid_out(vouto),
        .ready_out(routo), .count(cnto), .almost_full(afo),
        .dropped(drpo)
    );

    skid_fifo #(.DATA_WIDTH(8), .DEPTH(2), .OVERWRITE_MODE(0)) u2 (
        .clk(clk), .rst(rst), .data_in(din2), .valid_in(vin2),
        .ready_in(rdy2), .data_out(dout2), .valid_out(vout2),
        .ready_out(rout2), .count(cnt2), .almost_full(af2),
        .dropped(drp2)
    );

    typedef struct packed {
        logic       vin;
        logic [7:0] din;
        logic       rout;
        logic [2:0] cnt;
        logic       rdy;
        logic       vout;
        logic [7:0] dout;
        logic       af;
        logic       drp;
    } vec_t;

    function automatic vec_t mk(input logic vin, input logic [7:0] din,
                                input logic rout, input logic [2:0] cnt,
                                input logic rdy, input logic vout,
                                input logic [7:0] dout, input logic af,
                                input logic drp);
        vec_t v;
        v = '{vin, din, rout, cnt, rdy, vout, dout, af, drp};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input int sel, input vec_t v, input int idx);
        logic       r, vo, a, dp;
        logic [7:0] d;
        logic [2:0] c;
        string      t;
        if (sel == 0) begin
            vin4 = v.vin; din4 = v.din; rout4 = v.rout;
        end else begin
            vino = v.vin; dino = v.din; routo = v.rout;
        end
        step();
        if (sel == 0) begin
            r = rdy4; vo = vout4; d = dout4; c = cnt4; a = af4; dp = drp4;
        end else begin
            r = rdyo; vo = vouto; d = douto; c = cnto; a = afo; dp = drpo;
        end
        t = $sformatf("%s[%0d]", (sel == 0) ? "d4" : "ovr", idx);
        chk({t, " count"}, 32'(c), 32'(v.cnt));
        chk({t, " ready_in"}, 32'(r), 32'(v.rdy));
        chk({t, " valid_out"}, 32'(vo), 32'(v.vout));
        chk({t, " almost_full"}, 32'(a), 32'(v.af));
        chk({t, " dropped"}, 32'(dp), 32'(v.drp));
        if (v.vout) chk({t, " data_out"}, 32'(d), 32'(v.dout));
    endtask

    vec_t       t4[$];
    vec_t       to[$];
    logic [7:0] q[$];

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();
        chk("rst ready_in", 32'(rdy4), 32'd1);
        chk("rst valid_out", 32'(vout4), 32'd0);
        chk("rst count", 32'(cnt4), 32'd0);
        chk("rst dropped", 32'(drp4), 32'd0);
        chk("rst almost_full", 32'(af4), 32'd0);

        vin4 = 1;
        for (int i = 0; i < 3; i++) begin
            din4 = 8'(8'hA0 + i);
            step();
        end
        vin4 = 0;
        chk("pre-rst count", 32'(cnt4), 32'd3);
        rst = 1'b1;
        #1;
        chk("async rst count", 32'(cnt4), 32'd0);
        chk("async rst valid_out", 32'(vout4), 32'd0);
        chk("async rst ready_in", 32'(rdy4), 32'd1);
        chk("async rst data_out", 32'(dout4), 32'd0);
        chk("async rst almost_full", 32'(af4), 32'd0);
        #1 rst = 1'b0;

        t4.push_back(mk(1, 8'h11, 0, 1, 1, 1, 8'h11, 0, 0));
        t4.push_back(mk(1, 8'h22, 0, 2, 1, 1, 8'h11, 0, 0));
        t4.push_back(mk(1, 8'h33, 0, 3, 1, 1, 8'h11, 1, 0));
        t4.push_back(mk(1, 8'h44, 0, 4, 0, 1, 8'h11, 1, 0));
        t4.push_back(mk(1, 8'h55, 0, 4, 0, 1, 8'h11, 1, 0));
        t4.push_back(mk(0, 8'h00, 1, 3, 1, 1, 8'h22, 1, 0));
        t4.push_back(mk(0, 8'h00, 1, 2, 1, 1, 8'h33, 0, 0));
        t4.push_back(mk(0, 8'h00, 1, 1, 1, 1, 8'h44, 0, 0));
        t4.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0));
        foreach (t4[i]) apply(0, t4[i], i);

        vin4 = 1; rout4 = 1;
        for (int k = 1; k <= 12; k++) begin
            din4 = 8'(k);
            step();
            chk($sformatf("stream[%0d] data_out", k), 32'(dout4), 32'(k));
            chk($sformatf("stream[%0d] count", k), 32'(cnt4), 32'd1);
            chk($sformatf("stream[%0d] valid_out", k), 32'(vout4), 32'd1);
        end
        vin4 = 0; rout4 = 0;
        step();

        to.push_back(mk(1, 8'h01, 0, 1, 1, 1, 8'h01, 0, 0));
        to.push_back(mk(1, 8'h02, 0, 2, 1, 1, 8'h01, 0, 0));
        to.push_back(mk(1, 8'h03, 0, 3, 1, 1, 8'h01, 1, 0));
        to.push_back(mk(1, 8'h04, 0, 4, 1, 1, 8'h01, 1, 0));
        to.push_back(mk(1, 8'h05, 0, 4, 1, 1, 8'h02, 1, 1));
        to.push_back(mk(1, 8'h06, 0, 4, 1, 1, 8'h03, 1, 1));
        to.push_back(mk(1, 8'h07, 1, 4, 1, 1, 8'h04, 1, 0));
        to.push_back(mk(0, 8'h00, 1, 3, 1, 1, 8'h05, 1, 0));
        to.push_back(mk(0, 8'h00, 1, 2, 1, 1, 8'h06, 0, 0));
        to.push_back(mk(0, 8'h00, 1, 1, 1, 1, 8'h07, 0, 0));
        to.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0));
        foreach (to[i]) apply(1, to[i], i);

        begin
            bit acc = 1;
            bit ins, rem;
            for (int n = 0; n < 10000; n++) begin
                if (!vin2 || acc) begin
                    vin2 = ($urandom_range(0, 9) < 6);
                    din2 = 8'($urandom);
                end
                rout2 = ($urandom_range(0, 1) == 1);
                ins = vin2 && (q.size() < 2);
                rem = rout2 && (q.size() != 0);
                step();
                if (rem) void'(q.pop_front());
                if (ins) q.push_back(din2);
                acc = ins;
                chk("rand count", 32'(cnt2), 32'(q.size()));
                chk("rand valid_out", 32'(vout2), 32'(q.size() != 0));
                chk("rand ready_in", 32'(rdy2), 32'(q.size() < 2));
                if (q.size() != 0)
                    chk("rand data_out", 32'(dout2), 32'(q[0]));
            end
        end

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
